// File: rtl/quad_decoder_counter.sv
// Quadrature decoder with synchroniser, glitch filter, wrapping position counter and sticky error.
// Optional index input enc_z enabled by defining QDEC_INDEX_EN.
module quad_decoder_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enc_a,
  input  logic                  enc_b,
`ifdef QDEC_INDEX_EN
  input  logic                  enc_z,
`endif
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] qd,
  output logic                  up_pulse,
  output logic                  down_pulse,
  output logic                  dir,
  output logic                  err
);

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [3:0] STAB_MAX = 4'(FILTER_LEN - 1);

  logic [1:0] sync1;
  logic [1:0] s;
  logic [1:0] warm;
  logic [1:0] filt;
  logic [1:0] prev;
  logic [3:0] stab;
  logic       armed;
  logic       step_up;
  logic       step_down;
  logic       step_bad;
  logic       idx_hit;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1 <= '0;
      s     <= '0;
      warm  <= '0;
    end else begin
      sync1 <= {enc_a, enc_b};
      s     <= sync1;
      warm  <= {warm[0], 1'b1};
    end
  end

  // Arming waits for the synchroniser to hold real samples, then a full filter window.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      filt  <= '0;
      prev  <= '0;
      stab  <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      if (warm[1]) begin
        if (stab == STAB_MAX) begin
          filt  <= s;
          prev  <= s;
          stab  <= '0;
          armed <= 1'b1;
        end else begin
          stab <= stab + 4'd1;
        end
      end
    end else begin
      prev <= filt;
      if (s == filt) begin
        stab <= '0;
      end else if (stab == STAB_MAX) begin
        filt <= s;
        stab <= '0;
      end else begin
        stab <= stab + 4'd1;
      end
    end
  end

  always_comb begin
    step_up   = 1'b0;
    step_down = 1'b0;
    step_bad  = 1'b0;
    if (armed) begin
      case (prev)
        S00: begin
          step_up   = (filt == S10);
          step_down = (filt == S01);
          step_bad  = (filt == S11);
        end
        S10: begin
          step_up   = (filt == S11);
          step_down = (filt == S00);
          step_bad  = (filt == S01);
        end
        S11: begin
          step_up   = (filt == S01);
          step_down = (filt == S10);
          step_bad  = (filt == S00);
        end
        default: begin
          step_up   = (filt == S00);
          step_down = (filt == S11);
          step_bad  = (filt == S10);
        end
      endcase
    end
  end

`ifdef QDEC_INDEX_EN
  logic       z_sync1;
  logic       z_s;
  logic       z_filt;
  logic       z_prev;
  logic [3:0] z_stab;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      z_sync1 <= 1'b0;
      z_s     <= 1'b0;
      z_filt  <= 1'b0;
      z_prev  <= 1'b0;
      z_stab  <= '0;
    end else begin
      z_sync1 <= enc_z;
      z_s     <= z_sync1;
      if (!armed) begin
        z_filt <= z_s;
        z_prev <= z_s;
        z_stab <= '0;
      end else begin
        z_prev <= z_filt;
        if (z_s == z_filt) begin
          z_stab <= '0;
        end else if (z_stab == STAB_MAX) begin
          z_filt <= z_s;
          z_stab <= '0;
        end else begin
          z_stab <= z_stab + 4'd1;
        end
      end
    end
  end

  assign idx_hit = armed && z_filt && !z_prev;
`else
  assign idx_hit = 1'b0;
`endif

  // Load outranks index which outranks a step; pulses and dir follow the step regardless.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      qd         <= '0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      dir        <= 1'b1;
      err        <= 1'b0;
    end else begin
      if (load) begin
        qd <= d;
      end else if (idx_hit) begin
        qd <= '0;
      end else if (step_up) begin
        qd <= qd + DATA_WIDTH'(1);
      end else if (step_down) begin
        qd <= qd - DATA_WIDTH'(1);
      end
      up_pulse   <= step_up;
      down_pulse <= step_down;
      if (step_up) begin
        dir <= 1'b1;
      end else if (step_down) begin
        dir <= 1'b0;
      end
      err <= step_bad || (err && !err_clr);
    end
  end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Randomised and directed bench for quad_decoder_counter, checked against a position-arithmetic model.
module tb_quad_decoder_counter;
  localparam int FL = 3;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         enc_a = 1'b0;
  logic         enc_b = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] qd;
  logic         up_pulse;
  logic         down_pulse;
  logic         dir;
  logic         err;

  quad_decoder_counter #(.DATA_WIDTH(W), .FILTER_LEN(FL)) dut (
    .clk(clk), .clear(clear), .enc_a(enc_a), .enc_b(enc_b), .load(load), .d(d),
    .err_clr(err_clr), .qd(qd), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int up_cnt = 0;
  int dn_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: raw samples delayed two clocks, accepted after FL consecutive differing samples,
  // steps classified by the distance between Gray positions modulo 4.
  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  logic [1:0]   h1, h2, sv, m_filt, m_prev;
  int           m_run, m_edges, diff;
  bit           m_armed;
  logic [W-1:0] m_qd;
  logic         m_up, m_dn, m_dir, m_err;

  initial forever begin
    @(posedge clk or negedge clear);
    if (!clear) begin
      h1 = 0; h2 = 0; m_filt = 0; m_prev = 0; m_run = 0; m_edges = 0; m_armed = 0;
      m_qd = 0; m_up = 0; m_dn = 0; m_dir = 1; m_err = 0;
    end else begin
      sv = h2; h2 = h1; h1 = {enc_a, enc_b};
      diff = m_armed ? (gpos(m_filt) - gpos(m_prev) + 4) % 4 : 0;
      m_up = (diff == 1);
      m_dn = (diff == 3);
      if (load) m_qd = d;
      else if (m_up) m_qd = m_qd + 1;
      else if (m_dn) m_qd = m_qd - 1;
      if (m_up) m_dir = 1;
      else if (m_dn) m_dir = 0;
      m_err = (diff == 2) || (m_err && !err_clr);
      if (m_armed) begin
        m_prev = m_filt;
        if (sv == m_filt) m_run = 0;
        else begin
          m_run++;
          if (m_run == FL) begin
            m_filt = sv;
            m_run = 0;
          end
        end
      end else begin
        m_edges++;
        if (m_edges == 2 + FL) begin
          m_armed = 1; m_filt = sv; m_prev = sv; m_run = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("qd", qd, m_qd);
    chk("up_pulse", up_pulse, m_up);
    chk("down_pulse", down_pulse, m_dn);
    chk("dir", dir, m_dir);
    chk("err", err, m_err);
    if (up_pulse) up_cnt++;
    if (down_pulse) dn_cnt++;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] v, input int n);
    {enc_a, enc_b} = v;
    hold(n);
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] v, input bit up);
    case (v)
      2'b00:   return up ? 2'b10 : 2'b01;
      2'b10:   return up ? 2'b11 : 2'b00;
      2'b11:   return up ? 2'b01 : 2'b10;
      default: return up ? 2'b00 : 2'b11;
    endcase
  endfunction

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int ub, db;
    logic [1:0] cur;
    #1 clear = 1'b0;
    {enc_a, enc_b} = 2'b11;
    hold(3);
    chk("rst_qd", qd, 0);
    chk("rst_dir", dir, 1);
    chk("rst_err", err, 0);
    clear = 1'b1;
    hold(12);
    chk("arm_qd", qd, 0);
    chk("arm_err", err, 0);
    chk("arm_pulses", up_cnt + dn_cnt, 0);

    clear = 1'b0;
    {enc_a, enc_b} = 2'b00;
    hold(3);
    clear = 1'b1;
    hold(12);
    ub = up_cnt;
    {enc_a, enc_b} = 2'b10;
    hold(5);
    chk("lat_edge5_qd", qd, 0);
    hold(1);
    chk("lat_edge6_qd", qd, 1);
    chk("lat_edge6_up", up_pulse, 1);
    hold(4);
    set_ab(2'b11, 10);
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
    chk("rot_qd", qd, 4);
    chk("rot_ups", up_cnt - ub, 4);
    chk("rot_dir", dir, 1);

    load = 1'b1; d = 8'h00;
    hold(1);
    load = 1'b0;
    db = dn_cnt;
    set_ab(2'b01, 10);
    chk("wrap_down_qd", qd, 8'hFF);
    chk("wrap_down_cnt", dn_cnt - db, 1);
    chk("wrap_down_dir", dir, 0);
    load = 1'b1; d = 8'hFF;
    hold(1);
    load = 1'b0;
    set_ab(2'b00, 10);
    chk("wrap_up_qd", qd, 8'h00);

    ub = up_cnt;
    set_ab(2'b10, FL - 1);
    set_ab(2'b00, 10);
    chk("glitch_short_qd", qd, 0);
    chk("glitch_short_up", up_cnt - ub, 0);
    set_ab(2'b10, FL);
    set_ab(2'b00, 10);
    chk("glitch_accept_up", up_cnt - ub, 1);
    chk("glitch_accept_qd", qd, 0);

    ub = up_cnt; db = dn_cnt;
    set_ab(2'b11, 10);
    chk("illegal_err", err, 1);
    chk("illegal_qd", qd, 0);
    chk("illegal_pulses", (up_cnt - ub) + (dn_cnt - db), 0);
    {enc_a, enc_b} = 2'b00;
    hold(5);
    err_clr = 1'b1;
    hold(1);
    err_clr = 1'b0;
    chk("clr_vs_set_err", err, 1);
    hold(5);
    err_clr = 1'b1;
    hold(1);
    err_clr = 1'b0;
    chk("clr_alone_err", err, 0);

    {enc_a, enc_b} = 2'b10;
    hold(5);
    load = 1'b1; d = 8'h5A;
    hold(1);
    load = 1'b0;
    chk("collide_qd", qd, 8'h5A);
    chk("collide_up", up_pulse, 1);
    hold(4);

    {enc_a, enc_b} = 2'b11;
    hold(3);
    #2 clear = 1'b0;
    #1;
    chk("midrst_qd", qd, 0);
    chk("midrst_up", up_pulse, 0);
    chk("midrst_dn", down_pulse, 0);
    chk("midrst_dir", dir, 1);
    chk("midrst_err", err, 0);
    hold(3);
    clear = 1'b1;
    hold(12);
    chk("rearm_qd", qd, 0);
    chk("rearm_err", err, 0);
    set_ab(2'b01, 10);
    chk("rearm_step_qd", qd, 1);

    cur = 2'b01;
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) cur = nxt(cur, 1'b1);
      else if (op <= 6) cur = nxt(cur, 1'b0);
      else if (op == 8) cur = cur ^ 2'b11;
      else if (op == 9) begin
        set_ab(cur ^ 2'b10, $urandom_range(1, FL + 1));
      end
      {enc_a, enc_b} = cur;
      load = ($urandom_range(0, 7) == 0);
      d = W'($urandom);
      err_clr = ($urandom_range(0, 5) == 0);
      hold(1);
      load = 1'b0;
      err_clr = 1'b0;
      hold($urandom_range(0, 11));
    end
    hold(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
